wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width in bits (8, 16, 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width in bits.
REQ-003 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum bus cycles per attempt (range 2..65535).
REQ-005 SHALL have parameter MAX_RETRY, default 3, retries allowed after RTY (range 0..15).
REQ-006 SHALL have ports, one per line:
- i_clk  in  1  sole clock; all logic on rising edge
- i_rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  ADDR_WIDTH  target address
- cmd_dat  in  DATA_WIDTH  write data
- cmd_sel  in  SELECT_WIDTH  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_dat  out  DATA_WIDTH  read data (0 for writes and failures)
- rsp_status  out  2  00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT
- wb_adr_o  out  ADDR_WIDTH  ADR_O
- wb_dat_o  out  DATA_WIDTH  DAT_O
- wb_dat_i  in  DATA_WIDTH  DAT_I
- wb_we_o  out  1  WE_O
- wb_sel_o  out  SELECT_WIDTH  SEL_O
- wb_stb_o  out  1  STB_O
- wb_cyc_o  out  1  CYC_O
- wb_ack_i  in  1  ACK_I
- wb_err_i  in  1  ERR_I
- wb_rty_i  in  1  RTY_I

Function
REQ-007 SHALL implement FSM states IDLE, BUS, GAP, RESP; one transaction in flight at a time, no pipelining.
REQ-008 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch we/adr/dat/sel, clear retry and timeout counters, go BUS.
REQ-009 cmd_ready SHALL be 0 in BUS, GAP and RESP.
REQ-010 BUS: wb_cyc_o=wb_stb_o=1, wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o driven from latched values and held stable for the whole attempt.
REQ-011 Termination priority per cycle in BUS: ack > err > rty > timeout.
REQ-012 ack: status OK; rsp_dat=wb_dat_i sampled that edge if read, 0 if write; go RESP.
REQ-013 err: status ERR, rsp_dat=0, go RESP.
REQ-014 rty with retry count < MAX_RETRY: increment count, go GAP; rty with count = MAX_RETRY: status RETRY_EXHAUSTED, go RESP.
REQ-015 GAP: exactly one cycle with wb_cyc_o=wb_stb_o=0, timeout counter cleared, then BUS with unchanged latched command.
REQ-016 Timeout counter increments each BUS cycle without termination; after TIMEOUT_CYCLES BUS cycles with no termination: status TIMEOUT, rsp_dat=0, go RESP.
REQ-017 Termination in the same cycle the timeout limit is reached SHALL win over timeout.
REQ-018 wb_cyc_o and wb_stb_o SHALL deassert in the cycle immediately after the terminating edge.
REQ-019 RESP: rsp_valid=1, rsp_dat/rsp_status stable until rsp_valid&rsp_ready; then IDLE (cmd_ready=1 next cycle).
REQ-020 Latency: command accepted at edge N -> wb_stb_o high in cycle N+1; ack sampled at edge N+1 -> rsp_valid high in cycle N+2.
REQ-021 wb_ack_i/wb_err_i/wb_rty_i SHALL be ignored outside BUS.

Reset
REQ-022 i_rst low SHALL asynchronously force IDLE; cmd_ready=0 while in reset, 1 from the first cycle after release.
REQ-023 Reset values: rsp_valid=0, rsp_dat=0, rsp_status=00, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0, counters=0.
REQ-024 Reset mid-transaction SHALL drop wb_cyc_o/wb_stb_o immediately with no response issued.

Verification
REQ-025 Write 0x12345678 to adr 0x04, sel 0xF, ack on first stb cycle -> one bus cycle with we=1, rsp_status=00, rsp_dat=0, rsp_valid in cycle N+2.
REQ-026 Read adr 0x08, slave acks after 3 wait cycles with 0xDEADBEEF -> stb high 4 cycles, signals stable, rsp_dat=0xDEADBEEF, status 00.
REQ-027 Read with rty on every attempt, MAX_RETRY=3 -> 4 attempts separated by 1-cycle GAPs, status 10.
REQ-028 No termination, TIMEOUT_CYCLES=8 -> stb high exactly 8 cycles, status 11; ack+err in same cycle -> status 00.
REQ-029 rsp_ready held low 5 cycles -> rsp_valid and data held, cmd_ready=0; i_rst low during BUS -> cyc/stb 0 immediately, no rsp_valid.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master: turns one command into one bus
// transaction (with RTY retries and a per-attempt timeout) and one response.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// BUS   | cyc/stb asserted with the latched command, waiting for a termination
// GAP   | one idle bus cycle between an RTY and the next attempt
// RESP  | response presented until the consumer takes it
module wb_cmd_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic [1:0]              rsp_status,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_ERR     = 2'b01;
    localparam logic [1:0]  ST_RTY_EXH = 2'b10;
    localparam logic [1:0]  ST_TIMEOUT = 2'b11;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RTY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_GAP,
        S_RESP
    } state_t;

    state_t                  state, state_nxt;
    logic                    out_of_reset;
    logic                    accept;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_adr;
    logic [DATA_WIDTH-1:0]   lat_dat;
    logic [SELECT_WIDTH-1:0] lat_sel;
    logic [3:0]              rty_cnt, rty_cnt_nxt;
    logic [15:0]             tmo_cnt, tmo_cnt_nxt;
    logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_nxt;
    logic [1:0]              rsp_status_q, rsp_status_nxt;

    // cmd_ready stays low for the partial cycle between reset release and the first edge
    assign cmd_ready  = out_of_reset && (state == S_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;
    assign wb_cyc_o   = (state == S_BUS);
    assign wb_stb_o   = (state == S_BUS);
    assign wb_adr_o   = lat_adr;
    assign wb_dat_o   = lat_dat;
    assign wb_we_o    = lat_we;
    assign wb_sel_o   = lat_sel;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            out_of_reset <= 1'b0;
            rty_cnt      <= '0;
            tmo_cnt      <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
            lat_we       <= 1'b0;
            lat_adr      <= '0;
            lat_dat      <= '0;
            lat_sel      <= '0;
        end else begin
            state        <= state_nxt;
            out_of_reset <= 1'b1;
            rty_cnt      <= rty_cnt_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            rsp_dat_q    <= rsp_dat_nxt;
            rsp_status_q <= rsp_status_nxt;
            if (accept) begin
                lat_we  <= cmd_we;
                lat_adr <= cmd_adr;
                lat_dat <= cmd_dat;
                lat_sel <= cmd_sel;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        rty_cnt_nxt    = rty_cnt;
        tmo_cnt_nxt    = tmo_cnt;
        rsp_dat_nxt    = rsp_dat_q;
        rsp_status_nxt = rsp_status_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    rty_cnt_nxt = '0;
                    tmo_cnt_nxt = '0;
                    state_nxt   = S_BUS;
                end
            end
            S_BUS: begin
                // a termination on the last allowed cycle still beats the timeout
                if (wb_ack_i) begin
                    rsp_status_nxt = ST_OK;
                    rsp_dat_nxt    = lat_we ? '0 : wb_dat_i;
                    state_nxt      = S_RESP;
                end else if (wb_err_i) begin
                    rsp_status_nxt = ST_ERR;
                    rsp_dat_nxt    = '0;
                    state_nxt      = S_RESP;
                end else if (wb_rty_i) begin
                    if (rty_cnt < RTY_LIMIT) begin
                        rty_cnt_nxt = rty_cnt + 4'd1;
                        state_nxt   = S_GAP;
                    end else begin
                        rsp_status_nxt = ST_RTY_EXH;
                        rsp_dat_nxt    = '0;
                        state_nxt      = S_RESP;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    rsp_status_nxt = ST_TIMEOUT;
                    rsp_dat_nxt    = '0;
                    state_nxt      = S_RESP;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end
            S_GAP: begin
                tmo_cnt_nxt = '0;
                state_nxt   = S_BUS;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized and directed bench for wb_cmd_master; the bench acts as the
// Wishbone slave and predicts each outcome from a per-attempt slave plan.
module tb_wb_cmd_master;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;
    localparam int MR  = 3;

    // slave plan per attempt: 0 ack, 1 err, 2 rty, 3 never terminate, 4 ack+err
    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_NONE = 3, K_ACKERR = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_we_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;
    logic          wb_rty_i = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int plan_kind [0:15];
    int plan_wait [0:15];

    always #5 i_clk = ~i_clk;

    wb_cmd_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
        .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_plan(input int k, input int w);
        for (int i = 0; i < 16; i++) begin
            plan_kind[i] = k;
            plan_wait[i] = w;
        end
    endtask

    task automatic noise();
        wb_ack_i = 1'($urandom);
        wb_err_i = 1'($urandom);
        wb_rty_i = 1'($urandom);
        wb_dat_i = $urandom;
    endtask

    // Expected outcome straight from the protocol rules, attempt by attempt
    task automatic predict(input logic we, input logic [DW-1:0] rd,
                           output int status, output logic [DW-1:0] data,
                           output int attempts, output int stb_cycles);
        status = 0; data = '0; attempts = 0; stb_cycles = 0;
        for (int a = 0; a < 16; a++) begin
            attempts++;
            if (plan_kind[a] == K_NONE || plan_wait[a] >= TMO) begin
                stb_cycles += TMO;
                status = 3;
                break;
            end
            stb_cycles += plan_wait[a] + 1;
            if (plan_kind[a] == K_ACK || plan_kind[a] == K_ACKERR) begin
                status = 0;
                data   = we ? '0 : rd;
                break;
            end
            if (plan_kind[a] == K_ERR) begin
                status = 1;
                break;
            end
            if (a >= MR) begin
                status = 2;
                break;
            end
        end
    endtask

    // Called at a negedge; returns at a negedge with the master idle again.
    task automatic run_txn(input string name, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                           input logic [DW-1:0] rd, input int hold);
        int e_status, e_att, e_stb, e_lat;
        logic [DW-1:0] e_data;
        int att, c, stb_cnt, lat, gap_len, ai;
        logic prev_stb, got, stable, gap_bad, busy_rdy, held_bad, fire;
        logic [DW-1:0] first_dat;
        logic [1:0] first_status;

        predict(we, rd, e_status, e_data, e_att, e_stb);
        e_lat = e_stb + e_att;

        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        check({name, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);
        @(posedge i_clk); @(negedge i_clk);
        cmd_valid = 0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = '1;

        att = -1; c = 0; stb_cnt = 0; lat = 0; gap_len = 0;
        prev_stb = 0; got = 0; stable = 1; gap_bad = 0; busy_rdy = 0;
        for (int cyc = 1; cyc <= 300 && !got; cyc++) begin
            if (rsp_valid) begin
                got = 1;
                lat = cyc;
            end else begin
                if (cmd_ready) busy_rdy = 1;
                if (wb_stb_o) begin
                    if (!prev_stb) begin
                        att++;
                        c = 0;
                        if (att > 0 && gap_len != 1) gap_bad = 1;
                    end
                    stb_cnt++;
                    if (wb_cyc_o !== 1'b1 || wb_adr_o !== adr || wb_dat_o !== dat ||
                        wb_we_o !== we || wb_sel_o !== sel) stable = 0;
                    ai = (att < 16) ? att : 15;
                    fire = (plan_kind[ai] != K_NONE) && (c == plan_wait[ai]);
                    wb_ack_i = fire && (plan_kind[ai] == K_ACK || plan_kind[ai] == K_ACKERR);
                    wb_err_i = fire && (plan_kind[ai] == K_ERR || plan_kind[ai] == K_ACKERR);
                    wb_rty_i = fire && (plan_kind[ai] == K_RTY);
                    wb_dat_i = wb_ack_i ? rd : DW'($urandom);
                    c++;
                    gap_len = 0;
                end else begin
                    if (wb_cyc_o) stable = 0;
                    gap_len++;
                    noise();
                end
                prev_stb = wb_stb_o;
                @(posedge i_clk); @(negedge i_clk);
            end
        end
        check({name, " response seen"}, 64'(got), 64'd1);
        if (!got) begin
            wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
            return;
        end
        check({name, " status"}, 64'(rsp_status), 64'(e_status));
        check({name, " rsp_dat"}, 64'(rsp_dat), 64'(e_data));
        check({name, " attempts"}, 64'(att + 1), 64'(e_att));
        check({name, " stb cycles"}, 64'(stb_cnt), 64'(e_stb));
        check({name, " latency"}, 64'(lat), 64'(e_lat));
        check({name, " bus stable"}, 64'(stable), 64'd1);
        check({name, " one-cycle gaps"}, 64'(gap_bad), 64'd0);
        check({name, " cmd_ready busy"}, 64'(busy_rdy), 64'd0);

        first_dat = rsp_dat; first_status = rsp_status; held_bad = 0;
        for (int h = 0; h < hold; h++) begin
            noise();
            @(posedge i_clk); @(negedge i_clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== first_dat || rsp_status !== first_status ||
                cmd_ready !== 1'b0 || wb_stb_o !== 1'b0) held_bad = 1;
        end
        if (hold > 0) check({name, " response held"}, 64'(held_bad), 64'd0);
        noise();
        rsp_ready = 1;
        @(posedge i_clk); @(negedge i_clk);
        rsp_ready = 0;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        check({name, " rsp_valid after take"}, 64'(rsp_valid), 64'd0);
        check({name, " cmd_ready after take"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic          r_we;
        logic [DW-1:0] r_dat, r_rd;
        int            k;

        set_plan(K_NONE, 0);
        #12;
        check("reset cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_dat", 64'(rsp_dat), 64'd0);
        check("reset rsp_status", 64'(rsp_status), 64'd0);
        check("reset cyc/stb/we", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        check("reset adr/dat/sel", 64'(wb_adr_o) | 64'(wb_dat_o) | 64'(wb_sel_o), 64'd0);
        #10 i_rst = 1;
        @(negedge i_clk);
        check("cmd_ready after release", 64'(cmd_ready), 64'd1);

        set_plan(K_ACK, 0);
        run_txn("write ack0", 1'b1, 32'h04, 32'h1234_5678, 4'hF, 32'h0, 0);
        set_plan(K_ACK, 3);
        run_txn("read wait3", 1'b0, 32'h08, 32'h0, 4'hF, 32'hDEAD_BEEF, 0);
        set_plan(K_RTY, 0);
        run_txn("rty exhausted", 1'b0, 32'h10, 32'h0, 4'hF, 32'h1111_2222, 0);
        set_plan(K_NONE, 0);
        run_txn("timeout", 1'b0, 32'h14, 32'h0, 4'h3, 32'h0, 0);
        set_plan(K_ACKERR, 1);
        run_txn("ack+err", 1'b0, 32'h18, 32'h0, 4'hF, 32'hCAFE_F00D, 0);
        set_plan(K_ACK, TMO - 1);
        run_txn("ack at limit", 1'b0, 32'h1C, 32'h0, 4'hF, 32'h5A5A_A5A5, 0);
        set_plan(K_ERR, 2);
        run_txn("err hold5", 1'b1, 32'h20, 32'hFFFF_0000, 4'hC, 32'h0, 5);
        set_plan(K_RTY, 1);
        plan_kind[2] = K_ACK;
        run_txn("rty then ack", 1'b0, 32'h24, 32'h0, 4'hF, 32'h0BAD_F00D, 2);

        // reset in the middle of a bus attempt
        set_plan(K_NONE, 0);
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h40; cmd_dat = 32'h77; cmd_sel = 4'hF;
        @(posedge i_clk); @(negedge i_clk);
        cmd_valid = 0;
        repeat (2) @(negedge i_clk);
        check("pre-reset stb", 64'(wb_stb_o), 64'd1);
        #2 i_rst = 0;
        #1;
        check("mid reset cyc/stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        check("mid reset rsp_valid/cmd_ready", 64'({rsp_valid, cmd_ready}), 64'd0);
        @(negedge i_clk);
        #2 i_rst = 1;
        @(negedge i_clk);
        check("post reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("post reset cmd_ready", 64'(cmd_ready), 64'd1);

        for (int t = 0; t < 40; t++) begin
            for (int a = 0; a < 16; a++) begin
                k = $urandom_range(0, 9);
                plan_kind[a] = (k < 3) ? K_ACK : (k < 5) ? K_ERR : (k < 8) ? K_RTY :
                               (k < 9) ? K_ACKERR : K_NONE;
                plan_wait[a] = $urandom_range(0, 9);
            end
            r_we  = 1'($urandom);
            r_dat = $urandom;
            r_rd  = $urandom;
            run_txn($sformatf("rand%0d", t), r_we, $urandom, r_dat, 4'($urandom), r_rd,
                    $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
